// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_tx serial transmitter.
package piso_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } piso_state_e;

    // Bits needed to hold 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Word-in / bit-out bus of piso_tx. valid/ready: a word moves on the rising edge
// where din_valid && din_ready; the source holds din stable until that edge.
interface piso_tx_if
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             dout;
    logic             dout_valid;
    logic             frame_start;
    logic             busy;
    piso_state_e      state;

    modport master (
        output din, din_valid,
        input  din_ready, dout, dout_valid, frame_start, busy, state
    );

    modport slave (
        input  din, din_valid,
        output din_ready, dout, dout_valid, frame_start, busy, state
    );
endinterface

// File: rtl/piso_bitcnt.sv
// Load/decrement bit counter for piso_tx; last flags the final data bit.
module piso_bitcnt
    import piso_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          load_i,
    input  logic          dec_i,
    output logic [CW-1:0] cnt_o,
    output logic          last_o
);
    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at zero: the zero count always reloads or leaves SHIFT.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(WIDTH - 1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == '0);
endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter, gap-free back-to-back words.
// Define PIS_TX_PAR_EN to append an even-parity bit after each word.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic     clk,
    input  logic     clr_n,
    piso_tx_if.slave bus
);
    localparam int CW = clog2(WIDTH);

    piso_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dout_q, dout_d;
    logic             dv_q, dv_d;
    logic             fs_q, fs_d;
    logic             busy_q, busy_d;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             ready;
    logic             accept;
`ifdef PIS_TX_PAR_EN
    logic             par_q, par_d;
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    always_comb begin
        ready = 1'b0;
        if (clr_n) begin
            case (state_q)
                ST_IDLE:   ready = 1'b1;
`ifdef PIS_TX_PAR_EN
                ST_SHIFT:  ready = 1'b0;
                ST_PARITY: ready = 1'b1;
`else
                ST_SHIFT:  ready = last;
`endif
                default:   ready = 1'b0;
            endcase
        end
    end

    assign accept = bus.din_valid && ready;

    piso_bitcnt #(.WIDTH(WIDTH), .CW(CW)) u_bitcnt (
        .clk    (clk),
        .clr_n  (clr_n),
        .load_i (accept),
        .dec_i  ((state_q == ST_SHIFT) && !accept),
        .cnt_o  (cnt),
        .last_o (last)
    );

    // The register keeps the not-yet-sent bits; dout_q holds the bit on the wire.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        dout_d  = 1'b0;
        dv_d    = 1'b0;
        fs_d    = 1'b0;
        busy_d  = 1'b0;
`ifdef PIS_TX_PAR_EN
        par_d   = par_q;
`endif
        if (accept) begin
            state_d = ST_SHIFT;
            shreg_d = advance(bus.din);
            dout_d  = head(bus.din);
            dv_d    = 1'b1;
            fs_d    = 1'b1;
            busy_d  = 1'b1;
`ifdef PIS_TX_PAR_EN
            par_d   = ^bus.din;
`endif
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (!last) begin
                        shreg_d = advance(shreg_q);
                        dout_d  = head(shreg_q);
                        dv_d    = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
`ifdef PIS_TX_PAR_EN
                        state_d = ST_PARITY;
                        dout_d  = par_q;
                        dv_d    = 1'b1;
                        busy_d  = 1'b1;
`else
                        state_d = ST_IDLE;
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            dout_q  <= 1'b0;
            dv_q    <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PIS_TX_PAR_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
`ifdef PIS_TX_PAR_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.din_ready   = ready;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dv_q;
    assign bus.frame_start = fs_q;
    assign bus.busy        = busy_q;
    assign bus.state       = state_q;
endmodule
